// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings for the data-memory path: access widths (also consumed by the
// writeback dmem decoder), controller state codes and the store-encoder result.
package dmem_ctrl_pkg;

    localparam logic [1:0] DMEM_WIDTH_BYTE = 2'd0;
    localparam logic [1:0] DMEM_WIDTH_HALF = 2'd1;
    localparam logic [1:0] DMEM_WIDTH_WORD = 2'd2;

    localparam logic [1:0] DMEM_ST_IDLE   = 2'd0;
    localparam logic [1:0] DMEM_ST_REQ    = 2'd1;
    localparam logic [1:0] DMEM_ST_WAIT_R = 2'd2;
    localparam logic [1:0] DMEM_ST_DONE   = 2'd3;

    typedef struct packed {
        logic        misaligned;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } dmem_enc_t;

    // Width code 3 has no legal meaning, so it is reported like a misalignment.
    function automatic logic dmem_misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
        logic bad;
        case (width)
            DMEM_WIDTH_BYTE: bad = 1'b0;
            DMEM_WIDTH_HALF: bad = addr_lo[0];
            DMEM_WIDTH_WORD: bad = (addr_lo != 2'b00);
            default:         bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_encode.sv
// Store-side encoder: alignment check, byte strobes and lane-replicated write data.
// Counterpart of the writeback dmem decoder, which extracts lanes on the load side.
module dmem_encode
    import dmem_ctrl_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  width_i,
    input  logic        write_i,
    input  logic [31:0] wdata_i,
    output dmem_enc_t   enc_o
);

    logic [3:0] base_strb;

    always_comb begin
        base_strb        = 4'hF;
        enc_o.misaligned = dmem_misaligned(width_i, addr_lo_i);
        enc_o.wdata      = wdata_i;
        case (width_i)
            DMEM_WIDTH_BYTE: begin
                base_strb   = 4'b0001;
                enc_o.wdata = {4{wdata_i[7:0]}};
            end
            DMEM_WIDTH_HALF: begin
                base_strb   = 4'b0011;
                enc_o.wdata = {2{wdata_i[15:0]}};
            end
            default: begin
                base_strb = 4'hF;
            end
        endcase
        // Replication lets the bus pick any lane; the strobes select the real bytes.
        enc_o.wstrb = write_i ? (base_strb << addr_lo_i) : 4'b0000;
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: sequences one load/store at a time onto a valid/ready bus,
// stalls the pipeline meanwhile and registers the raw read word for writeback.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_width,
    input  logic        req_zero_ext,
    input  logic        flush,
    output logic        stall,
    output logic        fault,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        load_done,
    output logic [31:0] dmem_rdata,
    output logic [1:0]  dmem_word_addr,
    output logic [1:0]  dmem_width,
    output logic        dmem_zero_ext
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          squash_q, squash_d;
    logic          tmo_q, tmo_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    word_addr_q, word_addr_d;
    logic [1:0]    width_q, width_d;
    logic          zext_q, zext_d;

    dmem_enc_t enc;
    logic      live_req;
    logic      cnt_hit;
    logic      tmo_event;

    dmem_encode u_encode (
        .addr_lo_i (req_addr[1:0]),
        .width_i   (req_width),
        .write_i   (req_write),
        .wdata_i   (req_wdata),
        .enc_o     (enc)
    );

    assign live_req  = req_valid && !flush;
    assign cnt_hit   = (cnt_q == CW'(TIMEOUT - 1));
    // A handshake or read return in the last allowed cycle beats the timeout.
    assign tmo_event = cnt_hit && (((state_q == DMEM_ST_REQ) && !bus_ready) ||
                                   ((state_q == DMEM_ST_WAIT_R) && !bus_rvalid));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        squash_d    = squash_q;
        tmo_d       = tmo_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rdata_d     = rdata_q;
        word_addr_d = word_addr_q;
        width_d     = width_q;
        zext_d      = zext_q;
        case (state_q)
            DMEM_ST_IDLE: begin
                if (live_req && !enc.misaligned) begin
                    we_d        = req_write;
                    addr_d      = {req_addr[31:2], 2'b00};
                    wdata_d     = enc.wdata;
                    wstrb_d     = enc.wstrb;
                    word_addr_d = req_addr[1:0];
                    width_d     = req_width;
                    zext_d      = req_zero_ext;
                    cnt_d       = '0;
                    squash_d    = 1'b0;
                    tmo_d       = 1'b0;
                    state_d     = DMEM_ST_REQ;
                end
            end
            DMEM_ST_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (flush) squash_d = 1'b1;
                if (bus_ready) begin
                    state_d = we_q ? DMEM_ST_DONE : DMEM_ST_WAIT_R;
                end else if (tmo_event) begin
                    tmo_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DMEM_ST_DONE;
                end
            end
            DMEM_ST_WAIT_R: begin
                cnt_d = cnt_q + 1'b1;
                if (flush) squash_d = 1'b1;
                if (bus_rvalid) begin
                    rdata_d = bus_rdata;
                    state_d = DMEM_ST_DONE;
                end else if (tmo_event) begin
                    tmo_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DMEM_ST_DONE;
                end
            end
            default: begin
                squash_d = 1'b0;
                tmo_d    = 1'b0;
                state_d  = DMEM_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DMEM_ST_IDLE;
            cnt_q       <= '0;
            squash_q    <= 1'b0;
            tmo_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            word_addr_q <= '0;
            width_q     <= '0;
            zext_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            squash_q    <= squash_d;
            tmo_q       <= tmo_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            word_addr_q <= word_addr_d;
            width_q     <= width_d;
            zext_q      <= zext_d;
        end
    end

    // A rejected (misaligned) request must not hold the pipeline; it traps instead.
    assign stall     = live_req && (state_q != DMEM_ST_DONE) &&
                       !((state_q == DMEM_ST_IDLE) && enc.misaligned);
    assign fault     = ((state_q == DMEM_ST_IDLE) && live_req && enc.misaligned) ||
                       (tmo_event && !squash_q && !flush);
    assign load_done = (state_q == DMEM_ST_DONE) && !we_q && !squash_q && !tmo_q;

    assign bus_valid      = (state_q == DMEM_ST_REQ);
    assign bus_we         = we_q;
    assign bus_addr       = addr_q;
    assign bus_wdata      = wdata_q;
    assign bus_wstrb      = wstrb_q;
    assign dmem_rdata     = rdata_q;
    assign dmem_word_addr = word_addr_q;
    assign dmem_width     = width_q;
    assign dmem_zero_ext  = zext_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: stimulus pushes expected bus requests, loads and
// faults into queues; a negedge monitor pops and compares when the DUT presents them.
module tb_dmem_ctrl;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } busExp_t;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  wordAddr;
        logic [1:0]  width;
        logic        zext;
    } loadExp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, req_zero_ext, flush;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_width;
    logic        stall, fault, bus_valid, bus_ready, bus_we, bus_rvalid, load_done;
    logic [31:0] bus_addr, bus_wdata, bus_rdata, dmem_rdata;
    logic [3:0]  bus_wstrb;
    logic [1:0]  dmem_word_addr, dmem_width;
    logic        dmem_zero_ext;

    int errors = 0;
    int checks = 0;

    busExp_t  busQ[$];
    loadExp_t loadQ[$];
    string    faultQ[$];
    busExp_t  busExp;
    loadExp_t loadExp;
    string    faultName;

    dmem_ctrl #(.TIMEOUT(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_width      (req_width),
        .req_zero_ext   (req_zero_ext),
        .flush          (flush),
        .stall          (stall),
        .fault          (fault),
        .bus_valid      (bus_valid),
        .bus_ready      (bus_ready),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_wstrb      (bus_wstrb),
        .bus_rvalid     (bus_rvalid),
        .bus_rdata      (bus_rdata),
        .load_done      (load_done),
        .dmem_rdata     (dmem_rdata),
        .dmem_word_addr (dmem_word_addr),
        .dmem_width     (dmem_width),
        .dmem_zero_ext  (dmem_zero_ext)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [1:0] wid,
                                 input logic z, input logic f);
        req_valid    = v;
        req_write    = w;
        req_addr     = a;
        req_wdata    = d;
        req_width    = wid;
        req_zero_ext = z;
        flush        = f;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " bus_valid"}, bus_valid, 0);
        checkOutput({tag, " bus_we"}, bus_we, 0);
        checkOutput({tag, " bus_addr"}, bus_addr, 0);
        checkOutput({tag, " bus_wdata"}, bus_wdata, 0);
        checkOutput({tag, " bus_wstrb"}, bus_wstrb, 0);
        checkOutput({tag, " stall"}, stall, 0);
        checkOutput({tag, " fault"}, fault, 0);
        checkOutput({tag, " load_done"}, load_done, 0);
        checkOutput({tag, " dmem_rdata"}, dmem_rdata, 0);
        checkOutput({tag, " dmem_word_addr"}, dmem_word_addr, 0);
        checkOutput({tag, " dmem_width"}, dmem_width, 0);
        checkOutput({tag, " dmem_zero_ext"}, dmem_zero_ext, 0);
    endtask

    // Monitor: every handshake, load_done pulse and fault pulse must match the queue head.
    always @(negedge clk) begin
        if (bus_valid && bus_ready) begin
            if (busQ.size() == 0) begin
                checkOutput("unexpected bus handshake", 1, 0);
            end else begin
                busExp = busQ.pop_front();
                checkOutput("mon bus_we", bus_we, busExp.we);
                checkOutput("mon bus_addr", bus_addr, busExp.addr);
                checkOutput("mon bus_wstrb", bus_wstrb, busExp.strb);
                checkOutput("mon bus_wdata", bus_wdata, busExp.wdata);
            end
        end
        if (load_done) begin
            if (loadQ.size() == 0) begin
                checkOutput("unexpected load_done", 1, 0);
            end else begin
                loadExp = loadQ.pop_front();
                checkOutput("mon dmem_rdata", dmem_rdata, loadExp.rdata);
                checkOutput("mon dmem_word_addr", dmem_word_addr, loadExp.wordAddr);
                checkOutput("mon dmem_width", dmem_width, loadExp.width);
                checkOutput("mon dmem_zero_ext", dmem_zero_ext, loadExp.zext);
            end
        end
        if (fault) begin
            if (faultQ.size() == 0) begin
                checkOutput("unexpected fault", 1, 0);
            end else begin
                faultName = faultQ.pop_front();
                checkOutput({"mon fault ", faultName}, fault, 1);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetState("reset");
        nextCycle();
        rst = 1'b0;

        // Word load at 0x100, immediate ready, rvalid in WAIT_R: load_done in cycle 3.
        applyStimulus(1, 0, 32'h100, 0, 2'd2, 0, 0);
        bus_ready = 1'b1;
        busQ.push_back('{1'b0, 32'h100, 4'b0000, 32'h0});
        loadQ.push_back('{32'hDEADBEEF, 2'd0, 2'd2, 1'b0});
        @(negedge clk);
        checkOutput("t1 c0 stall", stall, 1);
        checkOutput("t1 c0 bus_valid", bus_valid, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("t1 c1 stall", stall, 1);
        checkOutput("t1 c1 bus_valid", bus_valid, 1);
        nextCycle();
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hDEADBEEF;
        @(negedge clk);
        checkOutput("t1 c2 stall", stall, 1);
        checkOutput("t1 c2 bus_valid", bus_valid, 0);
        nextCycle();
        bus_rvalid = 1'b0;
        @(negedge clk);
        checkOutput("t1 c3 load_done", load_done, 1);
        checkOutput("t1 c3 stall", stall, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        bus_ready = 1'b0;
        @(negedge clk);
        checkOutput("t1 idle load_done", load_done, 0);

        // Byte store 0xA5 at 0x203: strobe on lane 3, data replicated to all lanes.
        nextCycle();
        applyStimulus(1, 1, 32'h203, 32'h0000_00A5, 2'd0, 0, 0);
        bus_ready = 1'b1;
        busQ.push_back('{1'b1, 32'h200, 4'b1000, 32'hA5A5A5A5});
        nextCycle();
        @(negedge clk);
        checkOutput("t2 c1 bus_valid", bus_valid, 1);
        nextCycle();
        @(negedge clk);
        checkOutput("t2 c2 bus_valid", bus_valid, 0);
        checkOutput("t2 c2 load_done", load_done, 0);
        checkOutput("t2 c2 stall", stall, 0);
        checkOutput("t2 c2 dmem_word_addr", dmem_word_addr, 3);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        bus_ready = 1'b0;

        // Misaligned half load at 0x101: same-cycle fault, no stall, no bus request.
        nextCycle();
        applyStimulus(1, 0, 32'h101, 0, 2'd1, 0, 0);
        faultQ.push_back("half misaligned");
        @(negedge clk);
        checkOutput("t3 stall", stall, 0);
        checkOutput("t3 fault", fault, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t3 bus_valid", bus_valid, 0);
        checkOutput("t3 fault cleared", fault, 0);

        // Width code 3 is illegal even when word aligned.
        nextCycle();
        applyStimulus(1, 0, 32'h400, 0, 2'd3, 0, 0);
        faultQ.push_back("illegal width");
        @(negedge clk);
        checkOutput("t3b fault", fault, 1);
        checkOutput("t3b stall", stall, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t3b bus_valid", bus_valid, 0);

        // Flush in IDLE: request ignored.
        nextCycle();
        applyStimulus(1, 0, 32'h500, 0, 2'd2, 0, 1);
        @(negedge clk);
        checkOutput("flush idle stall", stall, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("flush idle bus_valid", bus_valid, 0);

        // Half store at 0x102 with bus_ready low 3 cycles; request inputs change meanwhile.
        nextCycle();
        applyStimulus(1, 1, 32'h102, 32'h0000_1234, 2'd1, 0, 0);
        busQ.push_back('{1'b1, 32'h100, 4'b1100, 32'h12341234});
        for (int c = 1; c <= 4; c++) begin
            nextCycle();
            req_addr  = 32'h0000_0FF1;
            req_wdata = 32'hFFFF_FFFF;
            bus_ready = (c == 4);
            @(negedge clk);
            checkOutput($sformatf("t4 c%0d bus_valid", c), bus_valid, 1);
            checkOutput($sformatf("t4 c%0d bus_addr", c), bus_addr, 32'h100);
            checkOutput($sformatf("t4 c%0d bus_wdata", c), bus_wdata, 32'h12341234);
            checkOutput($sformatf("t4 c%0d bus_wstrb", c), bus_wstrb, 4'b1100);
            checkOutput($sformatf("t4 c%0d stall", c), stall, 1);
        end
        nextCycle();
        bus_ready = 1'b0;
        @(negedge clk);
        checkOutput("t4 done stall", stall, 0);
        checkOutput("t4 done bus_valid", bus_valid, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Zero-extended byte load at 0x102: no strobes, offset/width/flag registered.
        nextCycle();
        applyStimulus(1, 0, 32'h102, 0, 2'd0, 1, 0);
        bus_ready = 1'b1;
        busQ.push_back('{1'b0, 32'h100, 4'b0000, 32'h0});
        loadQ.push_back('{32'h000000C3, 2'd2, 2'd0, 1'b1});
        nextCycle();
        nextCycle();
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h000000C3;
        nextCycle();
        bus_rvalid = 1'b0;
        bus_ready  = 1'b0;
        @(negedge clk);
        checkOutput("t8 load_done", load_done, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Timeout: word load at 0x300, bus never ready; fault in the 8th REQ cycle.
        nextCycle();
        applyStimulus(1, 0, 32'h300, 0, 2'd2, 0, 0);
        faultQ.push_back("timeout");
        @(negedge clk);
        checkOutput("t5 c0 stall", stall, 1);
        for (int c = 1; c <= 8; c++) begin
            nextCycle();
            @(negedge clk);
            checkOutput($sformatf("t5 c%0d bus_valid", c), bus_valid, 1);
            checkOutput($sformatf("t5 c%0d fault", c), fault, (c == 8));
        end
        nextCycle();
        @(negedge clk);
        checkOutput("t5 done bus_valid", bus_valid, 0);
        checkOutput("t5 done dmem_rdata", dmem_rdata, 0);
        checkOutput("t5 done load_done", load_done, 0);
        checkOutput("t5 done fault", fault, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Flush during WAIT_R: read still consumed, load_done suppressed.
        nextCycle();
        applyStimulus(1, 0, 32'h104, 0, 2'd2, 0, 0);
        bus_ready = 1'b1;
        busQ.push_back('{1'b0, 32'h104, 4'b0000, 32'h0});
        nextCycle();
        nextCycle();
        bus_ready = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        checkOutput("t6 flush stall", stall, 0);
        nextCycle();
        flush      = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h12345678;
        nextCycle();
        bus_rvalid = 1'b0;
        @(negedge clk);
        checkOutput("t6 done load_done", load_done, 0);
        checkOutput("t6 done fault", fault, 0);
        checkOutput("t6 done dmem_rdata", dmem_rdata, 32'h12345678);
        nextCycle();
        @(negedge clk);
        checkOutput("t6 idle bus_valid", bus_valid, 0);

        // Reset asserted while in REQ: everything back to zero the next cycle.
        nextCycle();
        applyStimulus(1, 1, 32'h40, 32'hCAFEF00D, 2'd2, 0, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("t7 req bus_valid", bus_valid, 1);
        checkOutput("t7 req bus_wdata", bus_wdata, 32'hCAFEF00D);
        nextCycle();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        @(negedge clk);
        checkResetState("t7 rst");
        nextCycle();
        rst = 1'b0;
        repeat (3) nextCycle();

        checkOutput("busQ drained", busQ.size(), 0);
        checkOutput("loadQ drained", loadQ.size(), 0);
        checkOutput("faultQ drained", faultQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
